// File: rtl/hd63701_irq_ctrl.sv
// HD63701-class interrupt front-end: CLKx2 clock-enable divider plus a prioritised
// NMI / IRQ1 / internal-source arbiter presenting one registered request and vector.
module hd63701_irq_ctrl #(
  parameter int unsigned NSRC  = 8,
  parameter int unsigned DIV   = 2,
  parameter logic [7:0]  VBASE = 8'hF6
) (
  input  logic            CLKx2,
  input  logic            RST,
  output logic            CE,
  input  logic            NMI,
  input  logic            IRQ,
  input  logic [NSRC-1:0] IRQ_SRC,
  input  logic [NSRC-1:0] IRQ_EDGE,
  input  logic [NSRC-1:0] IRQ_MASK,
  input  logic            I_FLAG,
  input  logic            ACK,
  output logic            REQ,
  output logic            NMI_REQ,
  output logic [7:0]      VECT,
  output logic [3:0]      SRC_ID
);

  localparam logic [3:0] CntMax = 4'(DIV - 1);

  logic [3:0]      cnt_q;
  logic            ce;
  logic            nmi_hist_q, nmi_pend_q, nmi_pend_d;
  logic [NSRC-1:0] src_hist_q, src_pend_q, src_pend_d;
  logic            req_q, req_d;
  logic            nmi_req_q;
  logic [7:0]      vect_q, vect_d;
  logic [3:0]      sid_q, sid_d;
  logic            ack_ce;
  logic            found;

  // Gated by RST so CE stays low while reset is held, even for DIV=1.
  assign ce = (cnt_q == CntMax) && !RST;
  assign CE = ce;

  always_ff @(posedge CLKx2) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (cnt_q == CntMax) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

  assign ack_ce = ACK && ce;

  always_comb begin
    nmi_pend_d = (nmi_pend_q && !(ack_ce && sid_q == 4'd1)) || (NMI && !nmi_hist_q);
    src_pend_d = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (IRQ_EDGE[i]) begin
        // A fresh edge in the ACK cycle overrides the clear.
        src_pend_d[i] = (src_pend_q[i] && !(ack_ce && sid_q == 4'(i + 3))) ||
                        (IRQ_SRC[i] && !src_hist_q[i]);
      end else begin
        src_pend_d[i] = IRQ_SRC[i];
      end
    end

    req_d  = 1'b0;
    vect_d = 8'hFE;
    sid_d  = 4'd0;
    found  = 1'b0;
    if (nmi_pend_d) begin
      vect_d = 8'hFC;
      sid_d  = 4'd1;
      found  = 1'b1;
    end else if (!I_FLAG && IRQ) begin
      req_d  = 1'b1;
      vect_d = 8'hF8;
      sid_d  = 4'd2;
      found  = 1'b1;
    end
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (!found && !I_FLAG && src_pend_d[i] && IRQ_MASK[i]) begin
        req_d  = 1'b1;
        vect_d = VBASE - 8'(2 * i);
        sid_d  = 4'(i + 3);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLKx2) begin
    if (RST) begin
      nmi_hist_q <= 1'b1;
      src_hist_q <= '1;
      nmi_pend_q <= 1'b0;
      src_pend_q <= '0;
      req_q      <= 1'b0;
      nmi_req_q  <= 1'b0;
      vect_q     <= 8'hFE;
      sid_q      <= 4'd0;
    end else if (ce) begin
      nmi_hist_q <= NMI;
      src_hist_q <= IRQ_SRC;
      nmi_pend_q <= nmi_pend_d;
      src_pend_q <= src_pend_d;
      req_q      <= req_d;
      nmi_req_q  <= nmi_pend_d;
      vect_q     <= vect_d;
      sid_q      <= sid_d;
    end
  end

  assign REQ     = req_q;
  assign NMI_REQ = nmi_req_q;
  assign VECT    = vect_q;
  assign SRC_ID  = sid_q;

endmodule

// File: tb/tb_hd63701_irq_ctrl.sv
// Directed self-checking bench for hd63701_irq_ctrl with DIV=3, NSRC=8, VBASE=F6.
module tb_hd63701_irq_ctrl;

  logic       CLKx2 = 1'b0;
  logic       RST = 1'b1;
  logic       CE;
  logic       NMI = 1'b0;
  logic       IRQ = 1'b0;
  logic [7:0] IRQ_SRC = '0;
  logic [7:0] IRQ_EDGE = '0;
  logic [7:0] IRQ_MASK = '0;
  logic       I_FLAG = 1'b0;
  logic       ACK = 1'b0;
  logic       REQ;
  logic       NMI_REQ;
  logic [7:0] VECT;
  logic [3:0] SRC_ID;

  int checks = 0;
  int passed = 0;

  hd63701_irq_ctrl #(
    .NSRC (8),
    .DIV  (3),
    .VBASE(8'hF6)
  ) dut (
    .CLKx2   (CLKx2),
    .RST     (RST),
    .CE      (CE),
    .NMI     (NMI),
    .IRQ     (IRQ),
    .IRQ_SRC (IRQ_SRC),
    .IRQ_EDGE(IRQ_EDGE),
    .IRQ_MASK(IRQ_MASK),
    .I_FLAG  (I_FLAG),
    .ACK     (ACK),
    .REQ     (REQ),
    .NMI_REQ (NMI_REQ),
    .VECT    (VECT),
    .SRC_ID  (SRC_ID)
  );

  always #5 CLKx2 = ~CLKx2;

  // Advance through the next CE edge; returns 1 time unit after it.
  task automatic next_ce();
    int n = 0;
    @(negedge CLKx2);
    while (CE !== 1'b1 && n < 20) begin
      @(negedge CLKx2);
      n++;
    end
    if (CE !== 1'b1) begin
      checks++;
      $display("FAIL ce_timeout: CE=%b after %0d cycles, required 1", CE, n);
    end
    @(posedge CLKx2);
    #1;
  endtask

  // Observed tuple: {REQ, NMI_REQ, VECT, SRC_ID}.
  function automatic logic [13:0] obs();
    return {REQ, NMI_REQ, VECT, SRC_ID};
  endfunction

  task automatic test_reset();
    logic [13:0] exp;
    repeat (3) @(posedge CLKx2);
    #1;
    exp = {1'b0, 1'b0, 8'hFE, 4'd0};
    checks++;
    if (obs() !== exp || CE !== 1'b0)
      $display("FAIL reset_state: got %h CE=%b, required %h CE=0", obs(), CE, exp);
    else passed++;
    RST = 1'b0;
    for (int p = 1; p <= 9; p++) begin
      @(negedge CLKx2);
      checks++;
      if (CE !== ((p % 3) == 0))
        $display("FAIL ce_period_%0d: CE=%b, required %b", p, CE, (p % 3) == 0);
      else passed++;
      if (p <= 2) begin
        checks++;
        if (obs() !== exp)
          $display("FAIL pre_ce_outputs_%0d: got %h, required %h", p, obs(), exp);
        else passed++;
      end
    end
  endtask

  task automatic test_edge_src();
    IRQ_EDGE = 8'h04;
    IRQ_MASK = 8'h04;
    I_FLAG   = 1'b0;
    IRQ_SRC  = 8'h04;
    next_ce();
    checks++;
    if (obs() !== {1'b1, 1'b0, 8'hF2, 4'd5})
      $display("FAIL edge_src2_req: got %h, required %h", obs(), {1'b1, 1'b0, 8'hF2, 4'd5});
    else passed++;
    ACK = 1'b1;
    next_ce();
    ACK = 1'b0;
    checks++;
    if (obs() !== {1'b0, 1'b0, 8'hFE, 4'd0})
      $display("FAIL edge_src2_ack: got %h, required %h", obs(), {1'b0, 1'b0, 8'hFE, 4'd0});
    else passed++;
    next_ce();
    checks++;
    if (REQ !== 1'b0)
      $display("FAIL edge_src2_no_retrigger: REQ=%b, required 0", REQ);
    else passed++;
    IRQ_SRC = 8'h00;
    next_ce();
  endtask

  task automatic test_level_prio();
    IRQ_EDGE = 8'h00;
    IRQ_MASK = 8'h09;
    IRQ_SRC  = 8'h09;
    next_ce();
    checks++;
    if (obs() !== {1'b1, 1'b0, 8'hF6, 4'd3})
      $display("FAIL level_src0_wins: got %h, required %h", obs(), {1'b1, 1'b0, 8'hF6, 4'd3});
    else passed++;
    I_FLAG = 1'b1;
    next_ce();
    checks++;
    if (obs() !== {1'b0, 1'b0, 8'hFE, 4'd0})
      $display("FAIL level_iflag_block: got %h, required %h", obs(), {1'b0, 1'b0, 8'hFE, 4'd0});
    else passed++;
    I_FLAG  = 1'b0;
    IRQ_SRC = 8'h08;
    next_ce();
    checks++;
    if (obs() !== {1'b1, 1'b0, 8'hF0, 4'd6})
      $display("FAIL level_src3: got %h, required %h", obs(), {1'b1, 1'b0, 8'hF0, 4'd6});
    else passed++;
    IRQ_SRC = 8'h00;
    next_ce();
    checks++;
    if (obs() !== {1'b0, 1'b0, 8'hFE, 4'd0})
      $display("FAIL level_drop: got %h, required %h", obs(), {1'b0, 1'b0, 8'hFE, 4'd0});
    else passed++;
  endtask

  task automatic test_nmi();
    IRQ    = 1'b1;
    I_FLAG = 1'b1;
    NMI    = 1'b1;
    next_ce();
    checks++;
    if (obs() !== {1'b0, 1'b1, 8'hFC, 4'd1})
      $display("FAIL nmi_req: got %h, required %h", obs(), {1'b0, 1'b1, 8'hFC, 4'd1});
    else passed++;
    ACK = 1'b1;
    next_ce();
    ACK = 1'b0;
    checks++;
    if (obs() !== {1'b0, 1'b0, 8'hFE, 4'd0})
      $display("FAIL nmi_ack: got %h, required %h", obs(), {1'b0, 1'b0, 8'hFE, 4'd0});
    else passed++;
    I_FLAG = 1'b0;
    next_ce();
    checks++;
    if (obs() !== {1'b1, 1'b0, 8'hF8, 4'd2})
      $display("FAIL irq1_after_nmi: got %h, required %h", obs(), {1'b1, 1'b0, 8'hF8, 4'd2});
    else passed++;
    IRQ = 1'b0;
    NMI = 1'b0;
    next_ce();
  endtask

  task automatic test_mask_retain();
    IRQ_EDGE = 8'h20;
    IRQ_MASK = 8'h00;
    IRQ_SRC  = 8'h20;
    next_ce();
    checks++;
    if (REQ !== 1'b0)
      $display("FAIL masked_edge_hidden: REQ=%b, required 0", REQ);
    else passed++;
    IRQ_SRC  = 8'h00;
    IRQ_MASK = 8'h20;
    next_ce();
    checks++;
    if (obs() !== {1'b1, 1'b0, 8'hEC, 4'd8})
      $display("FAIL mask_retained: got %h, required %h", obs(), {1'b1, 1'b0, 8'hEC, 4'd8});
    else passed++;
    IRQ_SRC = 8'h20;
    ACK     = 1'b1;
    next_ce();
    ACK = 1'b0;
    checks++;
    if (obs() !== {1'b1, 1'b0, 8'hEC, 4'd8})
      $display("FAIL edge_with_ack: got %h, required %h", obs(), {1'b1, 1'b0, 8'hEC, 4'd8});
    else passed++;
    ACK = 1'b1;
    next_ce();
    ACK = 1'b0;
    checks++;
    if (REQ !== 1'b0)
      $display("FAIL ack_line_high: REQ=%b, required 0", REQ);
    else passed++;
    IRQ_SRC = 8'h00;
    next_ce();
  endtask

  task automatic test_reset_mid();
    NMI = 1'b1;
    next_ce();
    checks++;
    if (NMI_REQ !== 1'b1)
      $display("FAIL nmi_before_reset: NMI_REQ=%b, required 1", NMI_REQ);
    else passed++;
    RST = 1'b1;
    @(posedge CLKx2);
    #1;
    checks++;
    if (obs() !== {1'b0, 1'b0, 8'hFE, 4'd0} || CE !== 1'b0)
      $display("FAIL reset_mid_drop: got %h CE=%b, required %h CE=0", obs(), CE,
               {1'b0, 1'b0, 8'hFE, 4'd0});
    else passed++;
    @(posedge CLKx2);
    #1;
    RST = 1'b0;
    for (int k = 0; k < 3; k++) begin
      next_ce();
      checks++;
      if (NMI_REQ !== 1'b0 || SRC_ID !== 4'd0)
        $display("FAIL no_spurious_nmi_%0d: NMI_REQ=%b SRC_ID=%0d, required 0/0", k, NMI_REQ,
                 SRC_ID);
      else passed++;
    end
    NMI = 1'b0;
  endtask

  initial begin
    test_reset();
    test_edge_src();
    test_level_prio();
    test_nmi();
    test_mask_retain();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/hd63701_irq_ctrl.md
Name: hd63701_irq_ctrl

Overview:
- Parametrised interrupt front-end and clock-enable generator for the HD63701-class core.
- Replaces the fixed divide-by-2 clock and the NMI/IRQ/IRQ2/IRQ0/4-bit IRQ2V inputs with:
  - a CLKx2-domain clock enable of ratio DIV;
  - an NSRC-channel prioritised, maskable, per-channel edge/level interrupt arbiter that presents one request, its vector low byte and its source id to the sequencer.
- Sits between the peripheral interrupt lines and the sequencer; the sequencer acknowledges on vector fetch.

Parameters:
- NSRC, 8, number of internal IRQ2-class sources (1..8).
- DIV, 2, CLKx2 cycles per CE pulse (1..16).
- VBASE, 8'hF6, vector low byte of source 0; source i uses VBASE-2*i.

Ports:
- CLKx2 input 1: sole clock, all logic on rising edge.
- RST input 1: synchronous active-high reset.
- CE output 1: clock enable, high one CLKx2 cycle in every DIV.
- NMI input 1: non-maskable request, rising-edge sensitive.
- IRQ input 1: external IRQ1, level sensitive.
- IRQ_SRC input NSRC: internal source lines.
- IRQ_EDGE input NSRC: per-source mode, 1 = rising-edge latched, 0 = level.
- IRQ_MASK input NSRC: per-source enable, 1 = enabled.
- I_FLAG input 1: CPU I bit; 1 blocks everything except NMI.
- ACK input 1: sequencer vector-fetch acknowledge, sampled only when CE=1.
- REQ output 1: maskable request pending.
- NMI_REQ output 1: NMI pending.
- VECT output 8: vector low byte of the presented source (high byte is FF).
- SRC_ID output 4: presented source; 0=none, 1=NMI, 2=IRQ1, 3+i=IRQ_SRC[i].

Behaviour:
- Reset (RST=1 at an edge):
  - divider counter = 0, CE = 0;
  - all pending bits = 0;
  - edge-history registers = all ones, so lines held high through reset create no edge;
  - REQ = 0, NMI_REQ = 0, VECT = 8'hFE, SRC_ID = 0.
  - Reset mid-request drops everything in the same cycle.
- CE generation:
  - counter counts 0..DIV-1; CE = 1 on cycles where counter == DIV-1.
  - DIV=1: CE=1 on every cycle after reset release.
  - DIV=2: first CE on the 2nd cycle after release, then alternating.
- Sampling: all inputs are sampled only on cycles with CE=1. Non-CE cycles hold all state.
- Pending, updated on each CE cycle:
  - NMI: set on 0->1 versus history.
  - IRQ_SRC[i], edge mode: pending set on 0->1.
  - IRQ_SRC[i], level mode: pending = current level.
  - IRQ1: always level.
  - History registers load the current inputs.
- Arbitration on the updated pending state:
  - Priority: NMI > IRQ1 > IRQ_SRC[0] > ... > IRQ_SRC[NSRC-1].
  - IRQ1 and sources qualify only if I_FLAG=0; sources also need IRQ_MASK[i]=1.
  - Masked or I-blocked pending bits are retained, not cleared.
- Outputs are registered at the same CE edge; latency is 1 CE from the sampled edge or level to REQ/NMI_REQ/VECT/SRC_ID.
- VECT mapping:
  - NMI = FC; IRQ1 = F8; source i = VBASE-2*i;
  - none = FE, with SRC_ID=0.
- REQ = 1 when the winner is IRQ1 or a source. NMI_REQ = 1 when NMI is pending.
- ACK on a CE cycle clears the latched pending bit of the SRC_ID presented before that edge (NMI or edge-mode source).
  - Level sources and IRQ1 are not cleared; the device must drop its line.
  - A new rising edge on the same source in the ACK cycle wins: the bit stays set.
  - ACK with SRC_ID=0 is ignored. ACK on non-CE cycles is ignored.
- Simultaneous NMI and maskable requests: NMI is presented; the maskable request stays pending and is presented after the NMI ACK.

Test Plan:
- DIV=3 reset release -> CE high on cycles 3, 6, 9 after release; outputs at reset values (VECT=FE, SRC_ID=0) until the first CE.
- IRQ_SRC[2] edge mode, mask 1, I_FLAG 0, rising edge -> at the next CE: REQ=1, VECT=F2, SRC_ID=5. ACK at a CE with the line still high -> REQ=0, no retrigger.
- IRQ_SRC[0] and IRQ_SRC[3] level-high together, both masked on -> VECT=F6. Drop source 0 -> VECT=F0, SRC_ID=6.
- NMI rising edge while IRQ1 is high and I_FLAG=1 -> NMI_REQ=1, VECT=FC, REQ=0. ACK -> NMI_REQ=0, VECT=FE. Clear I_FLAG -> REQ=1, VECT=F8.
- Edge source with mask 0 gets an edge; later set mask 1 -> request appears at the next CE (pending retained). New edge coincident with ACK -> REQ stays 1.
- RST asserted while NMI_REQ=1, then released with NMI held high -> NMI_REQ stays 0 (history preset blocks a spurious edge).
